code_sequencer: RTL and testbench



---
 rtl/code_seq_pkg.sv | 17 +
 rtl/code_step_counter.sv | 64 ++++++
 rtl/code_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_code_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/code_seq_pkg.sv
// Shared types and constants for the code sequencer slice.
// Provides the sequencer state encoding and the default code range
// (5..13, 4 bits) used to drive the 4-bit code converter.
package code_seq_pkg;

    localparam int              CODE_W     = 4;
    localparam logic [CODE_W-1:0] CODE_START = 4'd5;
    localparam logic [CODE_W-1:0] CODE_LAST  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/code_step_counter.sv
// Code word register with preset, increment-with-clamp and restart.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (code -> START)
//   load        - take load_val (range already checked by the caller)
//   load_val    - preset word
//   inc         - advance by STEP, clamped to LAST
//   restart     - return to START
//   code        - current word (registered)
//   at_last     - code equals LAST
module code_step_counter
    import code_seq_pkg::*;
#(
    parameter int               WIDTH = CODE_W,
    parameter logic [WIDTH-1:0] START = CODE_START,
    parameter logic [WIDTH-1:0] LAST  = CODE_LAST,
    parameter logic [WIDTH-1:0] STEP  = 4'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             restart,
    output logic [WIDTH-1:0] code,
    output logic             at_last
);

    logic [WIDTH-1:0] code_r;
    logic [WIDTH-1:0] code_nxt_s;
    logic [WIDTH:0]   sum_s;

    // Next code word: preset beats restart beats increment.
    always_comb begin
        // One extra bit so a step past the top of the word range is seen, not wrapped.
        sum_s      = {1'b0, code_r} + {1'b0, STEP};
        code_nxt_s = code_r;
        if (load) begin
            code_nxt_s = load_val;
        end else if (restart) begin
            code_nxt_s = START;
        end else if (inc) begin
            if (sum_s > {1'b0, LAST}) begin
                code_nxt_s = LAST;
            end else begin
                code_nxt_s = sum_s[WIDTH-1:0];
            end
        end else begin
            code_nxt_s = code_r;
        end
    end

    // Code word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r <= START;
        end else begin
            code_r <= code_nxt_s;
        end
    end

    assign code    = code_r;
    assign at_last = (code_r == LAST);

endmodule

// File: rtl/code_sequencer.sv
// Registered upstream stage for the 4-bit code converter. Steps a code
// word from START to LAST, one word per accepted valid/ready transfer,
// with one-shot / wrap modes, pause/resume and preset load.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - begin / resume sequencing (level)
//   stop            - pause sequencing (highest priority)
//   mode            - 0 one-shot, 1 wrap (sampled at the LAST transfer)
//   load, load_val  - preset request and word (IDLE/PAUSE only, in range)
//   ready           - downstream accepts the presented word
//   a, b, c, d      - code[3..0] to the converter
//   valid           - a..d carry a word for transfer
//   busy            - in RUN or PAUSE
//   done            - one-shot sequence finished
//   load_err        - one-cycle pulse for a rejected load
module code_sequencer
    import code_seq_pkg::*;
#(
    parameter int               WIDTH = CODE_W,
    parameter logic [WIDTH-1:0] START = CODE_START,
    parameter logic [WIDTH-1:0] LAST  = CODE_LAST,
    parameter logic [WIDTH-1:0] STEP  = 4'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ready,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             load_err
);

    seq_state_t       state_r;
    seq_state_t       state_nxt_s;
    logic             valid_r;
    logic             busy_r;
    logic             done_r;
    logic             load_err_r;
    logic             load_err_nxt_s;
    logic             cnt_load_s;
    logic             cnt_inc_s;
    logic             cnt_restart_s;
    logic             load_ok_s;
    logic             xfer_s;
    logic [WIDTH-1:0] code_s;
    logic             at_last_s;

    assign load_ok_s = (load_val >= START) && (load_val <= LAST);
    // stop wins over a same-cycle handshake: the word is not consumed.
    assign xfer_s    = (state_r == ST_RUN) && valid_r && ready && !stop;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode with priority stop > load > start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_PAUSE: begin
                if (stop || load) begin
                    state_nxt_s = state_r;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_PAUSE;
                end else if (xfer_s && at_last_s && !mode) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop || load) begin
                    state_nxt_s = ST_DONE;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Counter controls and load-error decode for this cycle.
    always_comb begin
        cnt_load_s     = 1'b0;
        cnt_inc_s      = 1'b0;
        cnt_restart_s  = 1'b0;
        load_err_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_PAUSE: begin
                if (!stop && load) begin
                    cnt_load_s     = load_ok_s;
                    load_err_nxt_s = !load_ok_s;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_RUN: begin
                // A load in RUN is flagged but does not block the handshake,
                // so a word the downstream took is always followed by the next one.
                load_err_nxt_s = !stop && load;
                if (xfer_s) begin
                    if (at_last_s) begin
                        cnt_restart_s = mode;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end else begin
                    cnt_inc_s = 1'b0;
                end
            end
            ST_DONE: begin
                if (!stop && load) begin
                    load_err_nxt_s = 1'b1;
                end else if (!stop && start) begin
                    cnt_restart_s = 1'b1;
                end else begin
                    cnt_restart_s = 1'b0;
                end
            end
            default: begin
                cnt_load_s = 1'b0;
            end
        endcase
    end

    // Output flag registers, updated on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            valid_r    <= (state_nxt_s == ST_RUN);
            busy_r     <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_PAUSE);
            done_r     <= (state_nxt_s == ST_DONE);
            load_err_r <= load_err_nxt_s;
        end
    end

    code_step_counter #(
        .WIDTH (WIDTH),
        .START (START),
        .LAST  (LAST),
        .STEP  (STEP)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .load_val (load_val),
        .inc      (cnt_inc_s),
        .restart  (cnt_restart_s),
        .code     (code_s),
        .at_last  (at_last_s)
    );

    assign a        = code_s[3];
    assign b        = code_s[2];
    assign c        = code_s[1];
    assign d        = code_s[0];
    assign valid    = valid_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_code_sequencer.sv
// Self-checking bench for code_sequencer: a behavioural model tracked per
// clock and compared every cycle, plus literal word lists and flag values.
module tb_code_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0, stop = 1'b0, mode = 1'b0, load = 1'b0, ready = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       a, b, c, d, valid, busy, done, load_err;
    logic       a3, b3, c3, d3, valid3, busy3, done3, load_err3;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int dut_words[$];
    int dut3_words[$];
    int exp_q[$];

    // model: phase 0 idle, 1 run, 2 pause, 3 done
    int m_phase = 0;
    int m_code  = 5;
    int m_valid = 0, m_busy = 0, m_done = 0, m_err = 0;

    always #5 clk = ~clk;

    code_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .load(load), .load_val(load_val), .ready(ready),
        .a(a), .b(b), .c(c), .d(d), .valid(valid), .busy(busy),
        .done(done), .load_err(load_err)
    );

    // Second instance with a step of 3 to exercise clamping to LAST.
    code_sequencer #(.STEP(4'd3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .load(load), .load_val(load_val), .ready(ready),
        .a(a3), .b(b3), .c(c3), .d(d3), .valid(valid3), .busy(busy3),
        .done(done3), .load_err(load_err3)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_words(input string nm, input int got[$], input int exp[$]);
        check({nm, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_w%0d", nm, i), got[i], exp[i]);
    endtask

    // Behavioural model: what the outputs must be after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_code = 5; m_err = 0;
        end else begin
            m_err = 0;
            if (stop) begin
                if (m_phase == 1) m_phase = 2;
            end else if (load) begin
                if ((m_phase == 0 || m_phase == 2) && load_val >= 5 && load_val <= 13)
                    m_code = load_val;
                else
                    m_err = 1;
                if (m_phase == 1 && ready) begin
                    if (m_code == 13) begin
                        if (mode) m_code = 5; else m_phase = 3;
                    end else m_code = (m_code + 1 > 13) ? 13 : m_code + 1;
                end
            end else if (m_phase == 1) begin
                if (ready) begin
                    if (m_code == 13) begin
                        if (mode) m_code = 5; else m_phase = 3;
                    end else m_code = (m_code + 1 > 13) ? 13 : m_code + 1;
                end
            end else if (start) begin
                if (m_phase == 3) m_code = 5;
                m_phase = 1;
            end
        end
        m_valid = (m_phase == 1);
        m_busy  = (m_phase == 1 || m_phase == 2);
        m_done  = (m_phase == 3);
    end

    // Accepted-word logs taken from the DUT side of the handshake.
    always @(posedge clk) begin
        if (rst_n && valid && ready && !stop) dut_words.push_back(int'({a, b, c, d}));
        if (rst_n && valid3 && ready && !stop) dut3_words.push_back(int'({a3, b3, c3, d3}));
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_code", int'({a, b, c, d}), m_code);
            check("cyc_valid", int'(valid), m_valid);
            check("cyc_busy", int'(busy), m_busy);
            check("cyc_done", int'(done), m_done);
            check("cyc_load_err", int'(load_err), m_err);
        end
    end

    task automatic tick(input logic s, input logic sp, input logic ld,
                        input logic [3:0] lv, input logic rd, input logic md);
        @(negedge clk);
        start = s; stop = sp; load = ld; load_val = lv; ready = rd; mode = md;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; load = 1'b0; ready = 1'b0; mode = 1'b0; load_val = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_valid", int'(valid), 0);
        check("rst_code", int'({a, b, c, d}), 5);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // one-shot run 5..13
        dut_words.delete(); dut3_words.delete();
        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("os_first_code", int'({a, b, c, d}), 5);
        check("os_first_valid", int'(valid), 1);
        repeat (9) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        exp_q = '{5, 6, 7, 8, 9, 10, 11, 12, 13};
        check_words("os_words", dut_words, exp_q);
        check("os_done", int'(done), 1);
        check("os_valid", int'(valid), 0);
        check("os_busy", int'(busy), 0);
        check("os_code", int'({a, b, c, d}), 13);
        exp_q = '{5, 8, 11, 13};
        check_words("clamp_words", dut3_words, exp_q);
        check("clamp_done", int'(done3), 1);

        // wrap mode, 12 transfers
        dut_words.delete();
        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("wr_restart", int'({a, b, c, d}), 5);
        repeat (12) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        exp_q = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 5, 6, 7};
        check_words("wr_words", dut_words, exp_q);
        check("wr_code", int'({a, b, c, d}), 8);

        // stall at word 7
        repeat (8) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("st_at7", int'({a, b, c, d}), 7);
        tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check("st_hold1", int'({a, b, c, d}), 7);
        check("st_hold1_v", int'(valid), 1);
        tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check("st_hold2", int'({a, b, c, d}), 7);
        tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("st_next", int'({a, b, c, d}), 8);

        // pause at 9, preset 11, resume
        tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        dut_words.delete();
        tick(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ps_valid", int'(valid), 0);
        check("ps_code", int'({a, b, c, d}), 9);
        check("ps_busy", int'(busy), 1);
        tick(1'b0, 1'b0, 1'b1, 4'd11, 1'b0, 1'b0);
        check("ps_load", int'({a, b, c, d}), 11);
        check("ps_load_err", int'(load_err), 0);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ps_resume_v", int'(valid), 1);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        exp_q = '{11, 12, 13};
        check_words("ps_words", dut_words, exp_q);
        check("ps_done", int'(done), 1);

        // load rejected in DONE
        tick(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        check("le_done_err", int'(load_err), 1);
        check("le_done_code", int'({a, b, c, d}), 13);
        tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("le_done_pulse", int'(load_err), 0);

        // out-of-range load in IDLE, start+stop in IDLE
        do_reset();
        tick(1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        check("le_idle_err", int'(load_err), 1);
        check("le_idle_code", int'({a, b, c, d}), 5);
        tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("le_idle_pulse", int'(load_err), 0);
        tick(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ss_valid", int'(valid), 0);
        check("ss_busy", int'(busy), 0);

        // asynchronous reset mid-run at word 10
        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ar_at10", int'({a, b, c, d}), 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", int'(valid), 0);
        check("ar_code", int'({a, b, c, d}), 5);
        check("ar_busy", int'(busy), 0);
        check("ar_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ar_restart", int'({a, b, c, d}), 5);
        tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ar_next", int'({a, b, c, d}), 6);
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
